// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop.
// Bit period is PRESCALE clock cycles, latched at accept.
// Build option: define UART_TX_PARITY_EN to include the parity bit (PAR_EN/PAR_TYP honoured).
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic                      TX_OUT,
    output logic                      BUSY
);

    localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = PRESCALE_WIDTH'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      bit_end;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    // Last cycle of the current serial bit; presc_q is never zero so this cannot stall.
    assign bit_end = (cnt_q == presc_q - PRESC_ONE);

    // Next-state logic: accept, bit timing, frame sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        bit_d   = bit_q;
        data_d  = data_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
`endif
        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + PRESC_ONE;
        end
        case (state_q)
            StIdle: begin
                if (DATA_VALID) begin
                    data_d  = P_DATA;
                    // A zero prescale would never reach its terminal count; run it as 1.
                    presc_d = (PRESCALE == '0) ? PRESC_ONE : PRESCALE;
                    cnt_d   = '0;
                    bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
`endif
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? StParity : StStop;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the next state so TX_OUT/BUSY come straight from flops.
    always_comb begin
        busy_d = (state_d != StIdle);
        case (state_d)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = (^data_d) ^ par_typ_d;
`endif
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            presc_q <= PRESC_ONE;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
`endif
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues expected frames, a line monitor
// decodes TX_OUT/BUSY cycle by cycle and checks each frame against the queue head.
module tb_uart_tx_serializer;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       BUSY;

    uart_tx_serializer #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        int         presc;   // effective cycles per bit
        bit         par;     // parity bit present
        logic       pbit;    // expected parity bit value
        int         gap;     // required idle cycles before this frame, 0 = don't care
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int flen(input frame_t f);
        return (f.par ? 11 : 10) * f.presc;
    endfunction

    function automatic logic exp_bit(input frame_t f, input int c);
        int b;
        b = c / f.presc;
        if (b == 0) return 1'b0;
        if (b <= 8) return f.data[b-1];
        if (f.par && b == 9) return f.pbit;
        return 1'b1;
    endfunction

    function automatic frame_t mk(input logic [7:0] d, input int p, input bit par,
                                  input logic pbit, input int gap);
        frame_t f;
        f.data = d; f.presc = p; f.par = par; f.pbit = pbit; f.gap = gap;
        return f;
    endfunction

    // Line monitor: samples on the falling edge, away from the register update.
    frame_t cur;
    bit     in_frame = 0;
    int     cyc      = 0;
    int     idle_cnt = 0;

    always @(negedge CLK) begin
        if (!RST) begin
            in_frame = 0;
            idle_cnt = 0;
        end else if (in_frame) begin
            if (cyc < flen(cur)) begin
                check($sformatf("busy d=%0h c=%0d", cur.data, cyc), BUSY, 1);
                check($sformatf("tx d=%0h c=%0d", cur.data, cyc), TX_OUT, exp_bit(cur, cyc));
                cyc++;
            end else begin
                check($sformatf("busy end d=%0h len=%0d", cur.data, cyc), BUSY, 0);
                check($sformatf("tx end d=%0h", cur.data), TX_OUT, 1);
                in_frame = 0;
                idle_cnt = 1;
            end
        end else if (BUSY) begin
            if (exp_q.size() == 0) begin
                check("unexpected frame start", BUSY, 0);
            end else begin
                cur = exp_q.pop_front();
                if (cur.gap > 0) check($sformatf("idle gap d=%0h", cur.data), idle_cnt, cur.gap);
                check($sformatf("tx d=%0h c=0", cur.data), TX_OUT, exp_bit(cur, 0));
                in_frame = 1;
                cyc = 1;
            end
        end else begin
            idle_cnt++;
            check("idle line high", TX_OUT, 1);
        end
    end

    // One-cycle DATA_VALID pulse; when acceptance is expected, the start bit must follow at once.
    task automatic send(input logic [7:0] d, input int p, input logic pe, input logic pt,
                        input bit expect_accept);
        P_DATA = d; PRESCALE = 6'(p); PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        if (expect_accept) begin
            check($sformatf("accept busy d=%0h", d), BUSY, 1);
            check($sformatf("accept start bit d=%0h", d), TX_OUT, 0);
        end else begin
            check($sformatf("dropped word busy d=%0h", d), BUSY, 1);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int t;
        t = 0;
        while ((BUSY || in_frame || exp_q.size() != 0) && t < budget) begin
            @(posedge CLK); #1;
            t++;
        end
        check({name, " completes in budget"}, (t < budget), 1);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   starts;
        int   t;
        logic prev;

        // Reset held with a pending request: line must stay idle.
        RST = 1'b0; DATA_VALID = 1'b1; P_DATA = 8'hA5; PRESCALE = 6'd8;
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check($sformatf("reset tx cyc%0d", i), TX_OUT, 1);
            check($sformatf("reset busy cyc%0d", i), BUSY, 0);
        end
        RST = 1'b1; DATA_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("post reset busy", BUSY, 0);

        // Basic frame: 0xA5 at 8 cycles/bit, 80-cycle frame.
        exp_q.push_back(mk(8'hA5, 8, 0, 1'b0, 0));
        send(8'hA5, 8, 1'b0, 1'b0, 1);
        wait_idle("frame A5", 200);

        // Parity frames: 0x07 has three ones -> even parity bit 1, odd parity bit 0.
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(mk(8'h07, 4, 1, 1'b1, 0));
        send(8'h07, 4, 1'b1, 1'b0, 1);
        wait_idle("even parity 07", 100);
        exp_q.push_back(mk(8'h07, 4, 1, 1'b0, 0));
        send(8'h07, 4, 1'b1, 1'b1, 1);
        wait_idle("odd parity 07", 100);
`else
        exp_q.push_back(mk(8'h07, 4, 0, 1'b0, 0));
        send(8'h07, 4, 1'b1, 1'b0, 1);
        wait_idle("parity ignored 07", 100);
`endif

        // Request while busy is dropped; changed inputs must not disturb the frame in flight.
        exp_q.push_back(mk(8'h3C, 4, 0, 1'b0, 0));
        send(8'h3C, 4, 1'b0, 1'b0, 1);
        repeat (10) @(posedge CLK);
        #1;
        send(8'hFF, 8, 1'b1, 1'b1, 0);
        wait_idle("busy drop 3C", 100);
        repeat (50) @(posedge CLK);
        #1;
        check("dropped word never sent", BUSY, 0);

        // PRESCALE=0 runs as one cycle per bit.
        exp_q.push_back(mk(8'h5A, 1, 0, 1'b0, 0));
        send(8'h5A, 0, 1'b0, 1'b0, 1);
        wait_idle("prescale zero 5A", 50);

        // Back-to-back with DATA_VALID held: one idle cycle between frames.
        exp_q.push_back(mk(8'h55, 16, 0, 1'b0, 0));
        exp_q.push_back(mk(8'h55, 16, 0, 1'b0, 1));
        exp_q.push_back(mk(8'h55, 16, 0, 1'b0, 1));
        P_DATA = 8'h55; PRESCALE = 6'd16; PAR_EN = 1'b0; DATA_VALID = 1'b1;
        starts = 0; t = 0; prev = BUSY;
        while (starts < 3 && t < 1000) begin
            @(posedge CLK); #1;
            t++;
            if (BUSY && !prev) starts++;
            prev = BUSY;
        end
        DATA_VALID = 1'b0;
        check("back-to-back three starts", starts, 3);
        wait_idle("back-to-back 55", 600);

        // Reset during data bit 3 (frame cycles 128..159 at 32 cycles/bit).
        exp_q.push_back(mk(8'h96, 32, 0, 1'b0, 0));
        send(8'h96, 32, 1'b0, 1'b0, 1);
        repeat (140) @(posedge CLK);
        #1;
        check("pre-reset busy", BUSY, 1);
        RST = 1'b0;
        @(posedge CLK); #1;
        check("mid-frame reset tx", TX_OUT, 1);
        check("mid-frame reset busy", BUSY, 0);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("abandoned frame consumed", exp_q.size(), 0);
        check("idle after reset release", BUSY, 0);
        exp_q.push_back(mk(8'h96, 32, 0, 1'b0, 0));
        send(8'h96, 32, 1'b0, 1'b0, 1);
        wait_idle("fresh frame 96", 500);

        repeat (20) @(posedge CLK);
        #1;
        check("scoreboard drained", exp_q.size(), 0);
        check("no frame in flight", in_frame, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
